// File: rtl/spike_frame_decoder_if.sv
// Stream bundle for the spike frame decoder: incoming neuron words and the
// first-word-fall-through output queue handshake.
interface spike_frame_decoder_if #(
    parameter int IDX_W = 16
);
    logic [IDX_W-1:0] neuron;
    logic             neuron_valid;
    logic [IDX_W-1:0] out_data;
    logic             out_eof;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output neuron, neuron_valid, out_ready,
        input  out_data, out_eof, out_valid
    );

    modport slave (
        input  neuron, neuron_valid, out_ready,
        output out_data, out_eof, out_valid
    );
endinterface

// File: rtl/spike_frame_decoder.sv
// Receive end of the layer spike stream: frames SOF..EOF words into a FWFT FIFO of
// spike indices plus a per-frame count tag, tracks timesteps and flags protocol errors.
module spike_frame_decoder #(
    parameter int               IDX_W      = 16,
    parameter int               NEURON_NUM = 256,
    parameter logic [IDX_W-1:0] SOF        = 16'hF1FA,
    parameter logic [IDX_W-1:0] EOF        = 16'hFAF1,
    parameter int               FIFO_DEPTH = 512,
    parameter int               FIFO_AW    = 9,
    parameter int               CNT_W      = 9,
    parameter int               TIMESTEPS  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    spike_frame_decoder_if.slave bus,
    input  logic                 clr_err,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     frame_spike_cnt,
    output logic [3:0]           timestep_num,
    output logic [FIFO_AW:0]     fifo_level,
    output logic                 overflow,
    output logic                 err_seq,
    output logic                 err_range
);
    typedef enum logic {IDLE, FRAME} state_t;

    localparam logic [IDX_W:0] IDX_LIM = (IDX_W+1)'(NEURON_NUM);
    localparam logic [3:0]     TS_LAST = 4'(TIMESTEPS - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   run_cnt, run_cnt_nxt;
    logic               push, seq_err, rng_err, eof_acc;
    logic [IDX_W:0]     push_word;
    logic [IDX_W:0]     mem [FIFO_DEPTH];
    logic [IDX_W:0]     head;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               pop, full, accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rstn) begin
            state   <= IDLE;
            run_cnt <= '0;
        end else begin
            state   <= state_nxt;
            run_cnt <= run_cnt_nxt;
        end
    end

    // Markers are decoded ahead of the range check so they never count as indices.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        push        = 1'b0;
        push_word   = '0;
        seq_err     = 1'b0;
        rng_err     = 1'b0;
        eof_acc     = 1'b0;
        if (bus.neuron_valid) begin
            case (state)
                IDLE: begin
                    if (bus.neuron == SOF) begin
                        state_nxt   = FRAME;
                        run_cnt_nxt = '0;
                    end else begin
                        seq_err = 1'b1;
                    end
                end
                FRAME: begin
                    if (bus.neuron == SOF) begin
                        seq_err     = 1'b1;
                        run_cnt_nxt = '0;
                    end else if (bus.neuron == EOF) begin
                        push      = 1'b1;
                        push_word = {1'b1, IDX_W'(run_cnt)};
                        eof_acc   = 1'b1;
                        state_nxt = IDLE;
                    end else if ({1'b0, bus.neuron} < IDX_LIM) begin
                        push        = 1'b1;
                        push_word   = {1'b0, bus.neuron};
                        run_cnt_nxt = sat_inc(run_cnt);
                    end else begin
                        rng_err = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign full   = fifo_level[FIFO_AW];
    assign pop    = bus.out_valid && bus.out_ready;
    assign accept = push && (!full || pop);

    assign head          = mem[rd_ptr];
    assign bus.out_valid = (fifo_level != '0);
    assign bus.out_data  = bus.out_valid ? head[IDX_W-1:0] : '0;
    assign bus.out_eof   = bus.out_valid && head[IDX_W];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_level      <= '0;
            overflow        <= 1'b0;
            frame_done      <= 1'b0;
            frame_spike_cnt <= '0;
            timestep_num    <= '0;
            err_seq         <= 1'b0;
            err_range       <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)    rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({accept, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
            overflow   <= (push && !accept) || (overflow && !clr_err);
            frame_done <= eof_acc;
            err_seq    <= seq_err;
            err_range  <= rng_err;
            if (eof_acc) begin
                frame_spike_cnt <= run_cnt;
                timestep_num    <= (timestep_num == TS_LAST) ? 4'd0 : timestep_num + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_spike_frame_decoder.sv
// Self-checking bench for spike_frame_decoder: directed frames plus a randomized
// stream, scored against a queue-based frame model.
module tb_spike_frame_decoder;
    localparam int         DEPTH = 512;
    localparam logic [15:0] SOFW = 16'hF1FA;
    localparam logic [15:0] EOFW = 16'hFAF1;

    logic       clk = 1'b0;
    logic       rstn;
    logic       clr_err;
    logic       frame_done;
    logic [8:0] frame_spike_cnt;
    logic [3:0] timestep_num;
    logic [9:0] fifo_level;
    logic       overflow, err_seq, err_range;

    spike_frame_decoder_if #(.IDX_W(16)) bus ();

    spike_frame_decoder dut (
        .clk             (clk),
        .rstn            (rstn),
        .bus             (bus),
        .clr_err         (clr_err),
        .frame_done      (frame_done),
        .frame_spike_cnt (frame_spike_cnt),
        .timestep_num    (timestep_num),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .err_seq         (err_seq),
        .err_range       (err_range)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Frame model: entries are {eof, data}
    bit          m_frame;
    int          m_cnt, m_ts, m_fcnt;
    logic [16:0] m_q[$];
    bit          m_ovf, m_done, m_eseq, m_erng;

    task automatic model_clear();
        m_frame = 0; m_cnt = 0; m_ts = 0; m_fcnt = 0;
        m_q.delete();
        m_ovf = 0; m_done = 0; m_eseq = 0; m_erng = 0;
    endtask

    task automatic model_push(input logic [16:0] e, inout bit drop);
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else drop = 1;
    endtask

    // One clock with the given inputs; model advances alongside, outputs sampled 1 after the edge.
    task automatic cyc(input bit v, input logic [15:0] w, input bit rdy, input bit clr);
        bit drop;
        drop = 0;
        bus.neuron_valid = v; bus.neuron = w; bus.out_ready = rdy; clr_err = clr;
        m_done = 0; m_eseq = 0; m_erng = 0;
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (v) begin
            if (w == SOFW) begin
                if (m_frame) m_eseq = 1;
                m_frame = 1; m_cnt = 0;
            end else if (w == EOFW) begin
                if (!m_frame) m_eseq = 1;
                else begin
                    model_push({1'b1, 16'(m_cnt)}, drop);
                    m_done = 1; m_fcnt = m_cnt; m_ts = (m_ts + 1) % 8; m_frame = 0;
                end
            end else if (!m_frame) m_eseq = 1;
            else if (w >= 16'd256) m_erng = 1;
            else begin
                model_push({1'b0, w}, drop);
                m_cnt = (m_cnt < 511) ? m_cnt + 1 : 511;
            end
        end
        if (clr) m_ovf = 0;
        if (drop) m_ovf = 1;
        @(posedge clk);
        #1;
        bus.neuron_valid = 0; clr_err = 0;
    endtask

    task automatic rst_cyc();
        rstn = 1; bus.neuron_valid = 0; bus.out_ready = 0; clr_err = 0;
        @(posedge clk);
        #1;
        rstn = 0;
        model_clear();
    endtask

    task automatic test_reset();
        rstn = 1; bus.neuron_valid = 0; bus.neuron = '0; bus.out_ready = 0; clr_err = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 0;
        model_clear();
        checks++;
        if ({bus.out_valid, bus.out_eof, bus.out_data} !== 18'd0)
            $display("FAIL reset_head: got %h want 0", {bus.out_valid, bus.out_eof, bus.out_data});
        else passed++;
        checks++;
        if ({frame_done, frame_spike_cnt, timestep_num, fifo_level, overflow, err_seq, err_range} !== 27'd0)
            $display("FAIL reset_status: got %h want 0",
                     {frame_done, frame_spike_cnt, timestep_num, fifo_level, overflow, err_seq, err_range});
        else passed++;
    endtask

    task automatic test_nominal();
        logic [15:0] idx[3] = '{16'd3, 16'd17, 16'd255};
        int nerr;
        nerr = 0;
        cyc(1, SOFW, 1, 0);
        nerr += err_seq + err_range;
        for (int i = 0; i < 3; i++) begin
            cyc(1, idx[i], 1, 0);
            nerr += err_seq + err_range;
            checks++;
            if (!bus.out_valid || bus.out_eof || bus.out_data !== idx[i])
                $display("FAIL nominal_idx%0d: got v=%b e=%b d=%0d want v=1 e=0 d=%0d",
                         i, bus.out_valid, bus.out_eof, bus.out_data, idx[i]);
            else passed++;
        end
        cyc(1, EOFW, 1, 0);
        nerr += err_seq + err_range;
        checks++;
        if (bus.out_eof !== 1'b1 || bus.out_data !== 16'd3)
            $display("FAIL nominal_tag: got e=%b d=%0d want e=1 d=3", bus.out_eof, bus.out_data);
        else passed++;
        checks++;
        if (frame_done !== 1'b1 || frame_spike_cnt !== 9'd3 || timestep_num !== 4'd1)
            $display("FAIL nominal_done: got done=%b cnt=%0d ts=%0d want 1 3 1",
                     frame_done, frame_spike_cnt, timestep_num);
        else passed++;
        cyc(0, 16'd0, 1, 0);
        nerr += err_seq + err_range;
        checks++;
        if (frame_done !== 1'b0 || bus.out_valid !== 1'b0 || nerr != 0)
            $display("FAIL nominal_after: got done=%b valid=%b errs=%0d want 0 0 0",
                     frame_done, bus.out_valid, nerr);
        else passed++;
    endtask

    task automatic test_wrap();
        int ndone;
        ndone = 0;
        rst_cyc();
        for (int f = 0; f < 8; f++) begin
            cyc(1, SOFW, 1, 0);
            cyc(1, EOFW, 1, 0);
            ndone += frame_done;
            checks++;
            if (bus.out_eof !== 1'b1 || bus.out_data !== 16'd0)
                $display("FAIL wrap_tag%0d: got e=%b d=%0d want e=1 d=0", f, bus.out_eof, bus.out_data);
            else passed++;
        end
        cyc(0, 16'd0, 1, 0);
        checks++;
        if (timestep_num !== 4'd0 || ndone != 8 || m_ts != 0)
            $display("FAIL wrap_ts: got ts=%0d done=%0d want ts=0 done=8", timestep_num, ndone);
        else passed++;
    endtask

    task automatic test_protocol();
        cyc(1, 16'd5, 1, 0);
        checks++;
        if (err_seq !== 1'b1 || err_range !== 1'b0)
            $display("FAIL proto_idle_idx: got seq=%b rng=%b want 1 0", err_seq, err_range);
        else passed++;
        cyc(1, EOFW, 1, 0);
        checks++;
        if (err_seq !== 1'b1 || fifo_level !== 10'd0 || frame_done !== 1'b0)
            $display("FAIL proto_idle_eof: got seq=%b lvl=%0d done=%b want 1 0 0", err_seq, fifo_level, frame_done);
        else passed++;
        cyc(1, SOFW, 1, 0);
        cyc(1, 16'd300, 1, 0);
        checks++;
        if (err_range !== 1'b1 || err_seq !== 1'b0 || fifo_level !== 10'd0)
            $display("FAIL proto_range: got rng=%b seq=%b lvl=%0d want 1 0 0", err_range, err_seq, fifo_level);
        else passed++;
        cyc(1, SOFW, 1, 0);
        checks++;
        if (err_seq !== 1'b1 || err_range !== 1'b0)
            $display("FAIL proto_resof: got seq=%b rng=%b want 1 0", err_seq, err_range);
        else passed++;
        cyc(1, 16'd9, 1, 0);
        checks++;
        if (bus.out_data !== 16'd9 || bus.out_eof !== 1'b0)
            $display("FAIL proto_idx: got d=%0d e=%b want 9 0", bus.out_data, bus.out_eof);
        else passed++;
        cyc(1, EOFW, 1, 0);
        checks++;
        if (bus.out_eof !== 1'b1 || bus.out_data !== 16'd1 || frame_spike_cnt !== 9'd1)
            $display("FAIL proto_tag: got e=%b d=%0d cnt=%0d want 1 1 1", bus.out_eof, bus.out_data, frame_spike_cnt);
        else passed++;
        cyc(0, 16'd0, 1, 0);
    endtask

    task automatic test_overflow();
        cyc(1, SOFW, 0, 0);
        for (int i = 0; i < 600; i++) cyc(1, 16'(i % 256), 0, 0);
        cyc(1, EOFW, 0, 0);
        checks++;
        if (fifo_level !== 10'd512 || overflow !== 1'b1)
            $display("FAIL ovf_level: got lvl=%0d ovf=%b want 512 1", fifo_level, overflow);
        else passed++;
        checks++;
        if (frame_done !== 1'b1 || frame_spike_cnt !== 9'd511)
            $display("FAIL ovf_done: got done=%b cnt=%0d want 1 511", frame_done, frame_spike_cnt);
        else passed++;
        cyc(0, 16'd0, 0, 1);
        checks++;
        if (overflow !== 1'b0 || fifo_level !== 10'd512)
            $display("FAIL ovf_clr: got ovf=%b lvl=%0d want 0 512", overflow, fifo_level);
        else passed++;
    endtask

    task automatic test_full_pop();
        cyc(1, SOFW, 0, 0);
        cyc(1, 16'd77, 1, 0);
        checks++;
        if (fifo_level !== 10'd512 || overflow !== 1'b0 || bus.out_data !== 16'd1)
            $display("FAIL full_pop: got lvl=%0d ovf=%b head=%0d want 512 0 1", fifo_level, overflow, bus.out_data);
        else passed++;
        cyc(1, EOFW, 0, 0);
        checks++;
        if (overflow !== 1'b1 || frame_done !== 1'b1 || frame_spike_cnt !== 9'd1 || timestep_num !== 4'(m_ts))
            $display("FAIL full_eof_drop: got ovf=%b done=%b cnt=%0d ts=%0d want 1 1 1 %0d",
                     overflow, frame_done, frame_spike_cnt, timestep_num, m_ts);
        else passed++;
        cyc(0, 16'd0, 0, 1);
        for (int i = 0; i < 600 && m_q.size() > 0; i++) begin
            cyc(0, 16'd0, 1, 0);
            checks++;
            if ({bus.out_valid, bus.out_eof, bus.out_data} !== ((m_q.size() > 0) ? {1'b1, m_q[0]} : 18'd0))
                $display("FAIL drain_head%0d: got %h want %h", i, {bus.out_valid, bus.out_eof, bus.out_data},
                         (m_q.size() > 0) ? {1'b1, m_q[0]} : 18'd0);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, SOFW, 0, 0);
        cyc(1, 16'd1, 0, 0);
        cyc(1, 16'd2, 0, 0);
        rst_cyc();
        checks++;
        if (fifo_level !== 10'd0 || bus.out_valid !== 1'b0 || timestep_num !== 4'd0)
            $display("FAIL rstmid_clear: got lvl=%0d valid=%b ts=%0d want 0 0 0", fifo_level, bus.out_valid, timestep_num);
        else passed++;
        cyc(1, SOFW, 0, 0);
        cyc(1, 16'd4, 0, 0);
        cyc(1, EOFW, 0, 0);
        checks++;
        if (fifo_level !== 10'd2 || bus.out_data !== 16'd4 || bus.out_eof !== 1'b0 || timestep_num !== 4'd1)
            $display("FAIL rstmid_head: got lvl=%0d d=%0d e=%b ts=%0d want 2 4 0 1",
                     fifo_level, bus.out_data, bus.out_eof, timestep_num);
        else passed++;
        cyc(0, 16'd0, 1, 0);
        checks++;
        if (bus.out_eof !== 1'b1 || bus.out_data !== 16'd1 || fifo_level !== 10'd1)
            $display("FAIL rstmid_tag: got e=%b d=%0d lvl=%0d want 1 1 1", bus.out_eof, bus.out_data, fifo_level);
        else passed++;
        cyc(0, 16'd0, 1, 0);
    endtask

    task automatic test_random();
        int r;
        logic [15:0] w;
        rst_cyc();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)      w = SOFW;
            else if (r < 22) w = EOFW;
            else if (r < 27) w = 16'($urandom_range(256, 16'hF000));
            else             w = 16'($urandom_range(0, 255));
            cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
            checks++;
            if ({bus.out_valid, bus.out_eof, bus.out_data} !== ((m_q.size() > 0) ? {1'b1, m_q[0]} : 18'd0))
                $display("FAIL rand_head@%0d: got %h want %h", i, {bus.out_valid, bus.out_eof, bus.out_data},
                         (m_q.size() > 0) ? {1'b1, m_q[0]} : 18'd0);
            else passed++;
            checks++;
            if (fifo_level !== 10'(m_q.size()))
                $display("FAIL rand_level@%0d: got %0d want %0d", i, fifo_level, m_q.size());
            else passed++;
            checks++;
            if ({frame_done, err_seq, err_range} !== {m_done, m_eseq, m_erng})
                $display("FAIL rand_pulses@%0d: got %b want %b", i, {frame_done, err_seq, err_range},
                         {m_done, m_eseq, m_erng});
            else passed++;
            checks++;
            if ({frame_spike_cnt, timestep_num, overflow} !== {9'(m_fcnt), 4'(m_ts), m_ovf})
                $display("FAIL rand_status@%0d: got cnt=%0d ts=%0d ovf=%b want %0d %0d %b", i,
                         frame_spike_cnt, timestep_num, overflow, m_fcnt, m_ts, m_ovf);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrap();
        test_protocol();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
